fpadd_issue_arbiter: RTL and testbench

Round-robin issue controller sharing one pipelined FP add datapath (input conversion plus adder) between two requesters. Accepts operand/opcode/precision bundles over valid/ready handshakes, registers the winning bundle onto the datapath inputs, and tracks each op's owner through the fixed-latency pipeline with a tag shift register. Routes each returning result to the owning requester. Sits between the two issuing front-ends and the fpadd datapath.

---
 rtl/fpadd_issue_arbiter_if.sv | 49 ++++
 rtl/fpadd_issue_arbiter.sv | 116 +++++++++++
 tb/tb_fpadd_issue_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fpadd_issue_arbiter_if.sv
// Request, datapath and response bundle between the two issuing front-ends,
// the issue arbiter and the shared fpadd datapath.
interface fpadd_issue_arbiter_if;
    logic        en;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req0_op1;
    logic [63:0] req0_op2;
    logic [2:0]  req0_op_type;
    logic [1:0]  req0_P;
    logic [63:0] req1_op1;
    logic [63:0] req1_op2;
    logic [2:0]  req1_op_type;
    logic [1:0]  req1_P;
    logic        dp_valid;
    logic [63:0] dp_op1;
    logic [63:0] dp_op2;
    logic [2:0]  dp_op_type;
    logic [1:0]  dp_P;
    logic [63:0] dp_result;
    logic [1:0]  rsp_valid;
    logic [63:0] rsp_result;
    logic        rsp_err;
    logic [3:0]  inflight;
    logic        idle;
    logic [15:0] issue_cnt;

    modport master (
        input  en, req_valid,
        input  req0_op1, req0_op2, req0_op_type, req0_P,
        input  req1_op1, req1_op2, req1_op_type, req1_P,
        input  dp_result,
        output req_ready,
        output dp_valid, dp_op1, dp_op2, dp_op_type, dp_P,
        output rsp_valid, rsp_result, rsp_err,
        output inflight, idle, issue_cnt
    );

    modport slave (
        output en, req_valid,
        output req0_op1, req0_op2, req0_op_type, req0_P,
        output req1_op1, req1_op2, req1_op_type, req1_P,
        output dp_result,
        input  req_ready,
        input  dp_valid, dp_op1, dp_op2, dp_op_type, dp_P,
        input  rsp_valid, rsp_result, rsp_err,
        input  inflight, idle, issue_cnt
    );
endinterface

// File: rtl/fpadd_issue_arbiter.sv
// Round-robin issue of two requesters onto one fixed-latency fpadd datapath,
// with a tag pipe that routes each returning result back to its owner.
module fpadd_issue_arbiter #(
    parameter int LAT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    fpadd_issue_arbiter_if.master bus
);
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    typedef struct packed {
        logic vld;
        logic id;
        logic err;
    } tag_t;

    function automatic logic [63:0] resp_value(input logic err, input logic [63:0] r);
        return err ? QNAN : r;
    endfunction

    logic [1:0]  grant;
    logic        accept;
    logic        win_id;
    logic        last;
    logic [63:0] sel_op1;
    logic [63:0] sel_op2;
    logic [2:0]  sel_op_type;
    logic [1:0]  sel_P;
    tag_t        tag_p0;
    tag_t        tag_pipe [LAT];
    tag_t        tag_out;

    always_comb begin
        grant = 2'b00;
        if (bus.en) begin
            unique case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign accept      = |grant;
    assign win_id      = grant[1];
    assign sel_op1     = win_id ? bus.req1_op1     : bus.req0_op1;
    assign sel_op2     = win_id ? bus.req1_op2     : bus.req0_op2;
    assign sel_op_type = win_id ? bus.req1_op_type : bus.req0_op_type;
    assign sel_P       = win_id ? bus.req1_P       : bus.req0_P;
    assign bus.req_ready = grant;
    assign bus.idle      = (bus.inflight == 4'd0);
    assign tag_out       = tag_pipe[LAT-1];

    // Stage p0: winning bundle onto the datapath inputs, owner tag alongside dp_valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.dp_valid   <= 1'b0;
            bus.dp_op1     <= '0;
            bus.dp_op2     <= '0;
            bus.dp_op_type <= '0;
            bus.dp_P       <= '0;
            tag_p0         <= '0;
            last           <= 1'b1;
            bus.issue_cnt  <= '0;
        end else begin
            bus.dp_valid <= accept;
            tag_p0       <= '{vld: accept, id: win_id, err: (sel_P == 2'b11)};
            if (accept) begin
                bus.dp_op1     <= sel_op1;
                bus.dp_op2     <= sel_op2;
                bus.dp_op_type <= sel_op_type;
                bus.dp_P       <= sel_P;
                last           <= win_id;
                bus.issue_cnt  <= bus.issue_cnt + 16'd1;
            end
        end
    end

    // Tag delay: tag_pipe[LAT-1] lines up with the cycle dp_result is valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < LAT; k++) tag_pipe[k] <= '0;
        end else begin
            tag_pipe[0] <= tag_p0;
            for (int k = 1; k < LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    // Response stage: one-cycle pulse to the owner; result/err hold between pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rsp_valid  <= 2'b00;
            bus.rsp_result <= '0;
            bus.rsp_err    <= 1'b0;
        end else begin
            bus.rsp_valid <= 2'b00;
            if (tag_out.vld) begin
                bus.rsp_valid[tag_out.id] <= 1'b1;
                bus.rsp_result            <= resp_value(tag_out.err, bus.dp_result);
                bus.rsp_err               <= tag_out.err;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.inflight <= 4'd0;
        end else if (accept && !(|bus.rsp_valid)) begin
            bus.inflight <= bus.inflight + 4'd1;
        end else if (!accept && (|bus.rsp_valid)) begin
            bus.inflight <= bus.inflight - 4'd1;
        end
    end
endmodule

// File: tb/tb_fpadd_issue_arbiter.sv
// Directed bench for fpadd_issue_arbiter: echoing datapath model, scoreboard
// of expected responses, and a per-cycle model of counters and dp registers.
module tb_fpadd_issue_arbiter;
    localparam int LAT = 3;
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    typedef struct {
        int          due;
        logic [1:0]  vld;
        logic [63:0] res;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fpadd_issue_arbiter_if bus ();

    fpadd_issue_arbiter #(.LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Datapath stand-in: returns dp_op1 exactly LAT cycles after dp_valid
    logic [63:0] dp_pipe [LAT];
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) dp_pipe[k] <= dp_pipe[k-1];
        dp_pipe[0] <= bus.dp_op1;
    end
    assign bus.dp_result = dp_pipe[LAT-1];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sb[$];
    exp_t e_mon;

    // Stimulus-side knowledge of the current cycle's expected acceptance
    logic        acc_now = 1'b0;
    logic [63:0] acc_op1 = '0, acc_op2 = '0;
    logic [2:0]  acc_t = '0;
    logic [1:0]  acc_p = '0;
    logic        resp_exp_now = 1'b0;

    // Expected registered state
    int          m_inf = 0;
    logic [15:0] m_cnt = '0;
    logic        m_dpv = 1'b0;
    logic [63:0] m_op1 = '0, m_op2 = '0;
    logic [2:0]  m_t = '0;
    logic [1:0]  m_p = '0;
    logic [63:0] m_rres = '0;
    logic        m_rerr = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h, required %h", nm, cyc, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_inf = 0; m_cnt = '0; m_dpv = 1'b0;
            m_op1 = '0; m_op2 = '0; m_t = '0; m_p = '0;
        end else begin
            m_inf = m_inf + (acc_now ? 1 : 0) - (resp_exp_now ? 1 : 0);
            m_dpv = acc_now;
            if (acc_now) begin
                m_cnt = m_cnt + 16'd1;
                m_op1 = acc_op1; m_op2 = acc_op2; m_t = acc_t; m_p = acc_p;
            end
        end
    end

    // Monitor: every cycle compares registered outputs with the model and
    // pops the scoreboard when a response is due
    initial forever begin
        @(negedge clk);
        if (reset) begin
            resp_exp_now = 1'b0;
            m_rres = '0;
            m_rerr = 1'b0;
        end else begin
            chk("inflight",  64'(bus.inflight),   64'(m_inf));
            chk("idle",      64'(bus.idle),       64'(m_inf == 0));
            chk("issue_cnt", 64'(bus.issue_cnt),  64'(m_cnt));
            chk("dp_valid",  64'(bus.dp_valid),   64'(m_dpv));
            chk("dp_op1",    bus.dp_op1,          m_op1);
            chk("dp_op2",    bus.dp_op2,          m_op2);
            chk("dp_op_type", 64'(bus.dp_op_type), 64'(m_t));
            chk("dp_P",      64'(bus.dp_P),       64'(m_p));
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e_mon = sb.pop_front();
                resp_exp_now = 1'b1;
                chk("rsp_valid",  64'(bus.rsp_valid), 64'(e_mon.vld));
                chk("rsp_result", bus.rsp_result,     e_mon.res);
                chk("rsp_err",    64'(bus.rsp_err),   64'(e_mon.err));
                m_rres = e_mon.res;
                m_rerr = e_mon.err;
            end else begin
                resp_exp_now = 1'b0;
                chk("rsp_valid_quiet", 64'(bus.rsp_valid), 64'(2'b00));
                chk("rsp_result_hold", bus.rsp_result,     m_rres);
                chk("rsp_err_hold",    64'(bus.rsp_err),   64'(m_rerr));
            end
        end
    end

    task automatic drive(input logic e, input logic [1:0] v,
                         input logic [63:0] a01, input logic [63:0] a02,
                         input logic [2:0] t0, input logic [1:0] p0,
                         input logic [63:0] a11, input logic [63:0] a12,
                         input logic [2:0] t1, input logic [1:0] p1,
                         input logic [1:0] exp_rdy);
        exp_t x;
        @(negedge clk);
        bus.en = e; bus.req_valid = v;
        bus.req0_op1 = a01; bus.req0_op2 = a02; bus.req0_op_type = t0; bus.req0_P = p0;
        bus.req1_op1 = a11; bus.req1_op2 = a12; bus.req1_op_type = t1; bus.req1_P = p1;
        #1;
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        acc_now = |exp_rdy;
        if (exp_rdy != 2'b00) begin
            acc_op1 = exp_rdy[1] ? a11 : a01;
            acc_op2 = exp_rdy[1] ? a12 : a02;
            acc_t   = exp_rdy[1] ? t1  : t0;
            acc_p   = exp_rdy[1] ? p1  : p0;
            x.due = cyc + LAT + 2;
            x.vld = exp_rdy;
            x.err = (acc_p == 2'b11);
            x.res = x.err ? QNAN : acc_op1;
            sb.push_back(x);
        end
    endtask

    task automatic idle_cyc(input int n);
        repeat (n) drive(1'b1, 2'b00, '0, '0, '0, '0, '0, '0, '0, '0, 2'b00);
    endtask

    task automatic op0(input logic [63:0] a, input logic [1:0] p);
        drive(1'b1, 2'b01, a, ~a, 3'b001, p, '0, '0, '0, '0, 2'b01);
    endtask

    task automatic op1(input logic [63:0] a, input logic [1:0] p);
        drive(1'b1, 2'b10, '0, '0, '0, '0, a, ~a, 3'b100, p, 2'b10);
    endtask

    task automatic both(input logic e, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] exp_rdy);
        drive(e, 2'b11, a, ~a, 3'b010, 2'b01, b, ~b, 3'b011, 2'b10, exp_rdy);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_dp_valid"},   64'(bus.dp_valid),   '0);
        chk({tag, "_dp_op1"},     bus.dp_op1,          '0);
        chk({tag, "_dp_op2"},     bus.dp_op2,          '0);
        chk({tag, "_rsp_valid"},  64'(bus.rsp_valid),  '0);
        chk({tag, "_rsp_result"}, bus.rsp_result,      '0);
        chk({tag, "_rsp_err"},    64'(bus.rsp_err),    '0);
        chk({tag, "_inflight"},   64'(bus.inflight),   '0);
        chk({tag, "_idle"},       64'(bus.idle),       64'd1);
        chk({tag, "_issue_cnt"},  64'(bus.issue_cnt),  '0);
    endtask

    // Asynchronous assertion away from both clock edges; release just after a negedge
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        reset = 1'b1;
        acc_now = 1'b0;
        bus.req_valid = 2'b00;
        sb.delete();
        #1;
        check_reset_state(tag);
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.en = 1'b0; bus.req_valid = 2'b00;
        bus.req0_op1 = '0; bus.req0_op2 = '0; bus.req0_op_type = '0; bus.req0_P = '0;
        bus.req1_op1 = '0; bus.req1_op2 = '0; bus.req1_op_type = '0; bus.req1_P = '0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("por");
        reset = 1'b0;

        // Single op from requester 0, result echoed by the datapath stand-in
        drive(1'b1, 2'b01, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 3'b000, 2'b00,
              '0, '0, '0, '0, 2'b01);
        idle_cyc(LAT + 4);

        // Contention from reset: tie goes to requester 0 first, then alternates
        do_reset("rst1");
        for (int i = 0; i < 6; i++)
            both(1'b1, 64'h1000 + 64'(i), 64'h2000 + 64'(i), (i % 2 == 0) ? 2'b01 : 2'b10);
        idle_cyc(LAT + 4);
        chk("contention_issue_cnt", 64'(bus.issue_cnt), 64'd6);

        // Reserved precision returns quiet NaN with err, then a clean op clears err
        op1(64'h5555_AAAA_0000_1111, 2'b11);
        idle_cyc(2);
        op1(64'h3F80_0000_0000_0000, 2'b01);
        idle_cyc(LAT + 4);

        // en gating: last becomes 0, blocked for 4 cycles, then requester 1 wins
        op0(64'h7777, 2'b00);
        idle_cyc(1);
        repeat (4) both(1'b0, 64'hA0, 64'hB0, 2'b00);
        both(1'b1, 64'hA1, 64'hB1, 2'b10);
        idle_cyc(LAT + 4);

        // Reset with three ops in flight: nothing may come back afterwards
        op0(64'hC1, 2'b00);
        op0(64'hC2, 2'b00);
        op0(64'hC3, 2'b00);
        idle_cyc(1);
        do_reset("rst2");
        idle_cyc(LAT + 4);
        chk("post_reset_issue_cnt", 64'(bus.issue_cnt), 64'd0);

        // 65536 back-to-back acceptances wrap issue_cnt and keep the pipe full
        for (int i = 0; i < 65536; i++) op0(64'(i) + 64'h1_0000_0000, 2'b00);
        idle_cyc(1);
        chk("wrap_issue_cnt", 64'(bus.issue_cnt), 64'd0);
        idle_cyc(LAT + 4);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
